seq_gen: RTL and testbench



---
 rtl/seq_gen.sv | 138 +++++++++++++
 tb/tb_seq_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Serial pattern transmitter: loads a parallel pattern over valid/ready
// and shifts it out MSB-first with repeat count and inter-repeat gap.
module seq_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [REP_W-1:0] rep_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             abort_i,
  output logic             seq_out,
  output logic             seq_vld,
  output logic             busy,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam logic [LEN_W-1:0] LMAX = LEN_W'(PAT_W);

  state_t           state;
  logic [PAT_W-1:0] pat_r;
  logic [PAT_W-1:0] shreg;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] bit_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_r;
  logic [GAP_W-1:0] gap_cnt;

  logic [LEN_W-1:0] eff_len;
  logic [REP_W-1:0] eff_rep;
  logic [PAT_W-1:0] aligned;

  // Left-align the active field so the first bit is always the MSB.
  always_comb begin
    eff_len = len_i;
    if (len_i == '0 || len_i > LMAX) eff_len = LMAX;
    eff_rep = rep_i;
    if (rep_i == '0) eff_rep = REP_W'(1);
    aligned = pat_i << (LMAX - eff_len);
  end

  assign load_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pat_r   <= '0;
      shreg   <= '0;
      len_r   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_r   <= '0;
      gap_cnt <= '0;
      seq_out <= 1'b0;
      seq_vld <= 1'b0;
      busy    <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            pat_r   <= aligned;
            shreg   <= aligned << 1;
            len_r   <= eff_len;
            bit_cnt <= eff_len - 1'b1;
            rep_cnt <= eff_rep;
            gap_r   <= gap_i;
            seq_out <= aligned[PAT_W-1];
            seq_vld <= 1'b1;
            busy    <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (abort_i) begin
            state   <= IDLE;
            seq_out <= 1'b0;
            seq_vld <= 1'b0;
            busy    <= 1'b0;
          end else if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
            seq_out <= shreg[PAT_W-1];
            shreg   <= shreg << 1;
          end else if (rep_cnt > REP_W'(1)) begin
            rep_cnt <= rep_cnt - 1'b1;
            if (gap_r != '0) begin
              state   <= GAP;
              gap_cnt <= gap_r;
              seq_out <= 1'b0;
              seq_vld <= 1'b0;
            end else begin
              shreg   <= pat_r << 1;
              seq_out <= pat_r[PAT_W-1];
              bit_cnt <= len_r - 1'b1;
            end
          end else begin
            state   <= IDLE;
            done_o  <= 1'b1;
            seq_out <= 1'b0;
            seq_vld <= 1'b0;
            busy    <= 1'b0;
          end
        end
        GAP: begin
          if (abort_i) begin
            state   <= IDLE;
            seq_out <= 1'b0;
            seq_vld <= 1'b0;
            busy    <= 1'b0;
          end else if (gap_cnt > GAP_W'(1)) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else begin
            state   <= SEND;
            shreg   <= pat_r << 1;
            seq_out <= pat_r[PAT_W-1];
            seq_vld <= 1'b1;
            bit_cnt <= len_r - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: directed jobs plus random jobs
// checked cycle-by-cycle against a stream-building reference model.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] pat_i;
  logic [3:0] len_i;
  logic [3:0] rep_i;
  logic [3:0] gap_i;
  logic       abort_i;
  logic       seq_out;
  logic       seq_vld;
  logic       busy;
  logic       done_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Expected per-cycle {seq_out, seq_vld, busy, done_o, load_ready}
  logic [4:0] exp_q[$];

  seq_gen dut (
    .clk(clk),
    .rst(rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .pat_i(pat_i),
    .len_i(len_i),
    .rep_i(rep_i),
    .gap_i(gap_i),
    .abort_i(abort_i),
    .seq_out(seq_out),
    .seq_vld(seq_vld),
    .busy(busy),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {seq_out, seq_vld, busy, done_o, load_ready};
  endfunction

  task automatic check(input string tag, input logic [4:0] o,
                       input logic [4:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic build(input logic [7:0] pat, input int len,
                       input int rep, input int gap);
    int l;
    int r;
    l = (len == 0 || len > 8) ? 8 : len;
    r = (rep == 0) ? 1 : rep;
    exp_q.delete();
    for (int k = 0; k < r; k++) begin
      for (int b = l - 1; b >= 0; b--)
        exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0, 1'b0});
      if (k < r - 1)
        for (int g = 0; g < gap; g++)
          exp_q.push_back(5'b00100);
    end
    exp_q.push_back(5'b00011);
  endtask

  task automatic run_job(input logic [7:0] pat, input logic [3:0] len,
                         input logic [3:0] rep, input logic [3:0] gap,
                         input int abort_at, input int rst_at,
                         input string tag);
    build(pat, int'(len), int'(rep), int'(gap));
    pat_i = pat;
    len_i = len;
    rep_i = rep;
    gap_i = gap;
    load_valid = 1'b1;
    check({tag, "_ready"}, {4'b0000, load_ready}, 5'b00001);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, i), obs(), exp_q[i]);
      if (i == abort_at) begin
        abort_i = 1'b1;
        load_valid = 1'b0;
        @(negedge clk);
        abort_i = 1'b0;
        check({tag, "_abort"}, obs(), 5'b00001);
        @(negedge clk);
        check({tag, "_abort_nodone"}, obs(), 5'b00001);
        return;
      end
      if (i == rst_at) begin
        load_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check({tag, "_async"}, obs(), 5'b00001);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (exp_q[i][1]) begin
        load_valid = 1'b0;
      end else begin
        load_valid = 1'($urandom);
        pat_i = 8'($urandom);
        len_i = 4'($urandom);
        rep_i = 4'($urandom);
        gap_i = 4'($urandom);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    load_valid = 1'b1;
    pat_i = 8'hFF;
    len_i = 4'd3;
    rep_i = 4'd2;
    gap_i = 4'd1;
    abort_i = 1'b0;
    #1 check("reset_async", obs(), 5'b00001);
    @(negedge clk);
    check("reset_c1", obs(), 5'b00001);
    @(negedge clk);
    check("reset_c2", obs(), 5'b00001);
    load_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("reset_nolatch", obs(), 5'b00001);

    run_job(8'h16, 4'd5, 4'd1, 4'd0, -1, -1, "len5");
    run_job(8'h05, 4'd3, 4'd3, 4'd2, -1, -1, "rep3gap2");
    run_job(8'hA5, 4'd0, 4'd0, 4'd0, -1, -1, "len0");
    run_job(8'h3C, 4'd4, 4'd3, 4'd0, -1, -1, "b2b");
    run_job(8'hC3, 4'd8, 4'd1, 4'd0, 2, -1, "abort");
    run_job(8'h05, 4'd3, 4'd2, 4'd4, -1, 4, "rstgap");
    run_job(8'h16, 4'd5, 4'd1, 4'd0, -1, -1, "postrst");

    for (int j = 0; j < 30; j++)
      run_job(8'($urandom), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 4)), 4'($urandom_range(0, 3)),
              -1, -1, $sformatf("rnd%0d", j));

    load_valid = 1'b0;
    @(negedge clk);
    check("final_idle", obs(), 5'b00001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
